// File: rtl/poly_basemul_ctrl.sv
// poly_basemul_ctrl
//   Sequencer for the Kyber-512 NTT-domain pointwise product r = a o b
//   (q = 3329). Walks the 128 coefficient pairs. For each pair k it reads the
//   a/b pair words and zeta, drives the pair multiplier (basemul) through its
//   enable/done handshake, then writes the result pair to r memory.
//
//   Optional feature: define PBM_CYCLE_COUNT_EN to add the o_cycles busy-cycle
//   counter port. The default build has no counter and no o_cycles port.
//
// Ports
//   i_clk, i_rst           clock; synchronous active-high reset
//   i_start / o_busy       start pulse (ignored while busy) / busy flag
//   o_done                 one-cycle pulse after the last pair is written
//   o_rd_en, o_rd_addr     a/b pair read strobe and address (1-cycle latency)
//   i_a_pair, i_b_pair     {coef[2k+1], coef[2k]} read data
//   o_zeta_idx, i_zeta     zeta ROM index (k>>1) and returned zeta
//   o_bm_en                basemul enable, high while a pair is in flight
//   o_bm_p_*/o_bm_q_*      basemul operands; o_bm_zeta = zeta or Q-zeta
//   i_bm_r_h/l, i_bm_done  basemul result and done pulse
//   o_wr_en/addr/data      r memory write port
//   o_cycles               busy-cycle counter (PBM_CYCLE_COUNT_EN only)
module poly_basemul_ctrl #(
  parameter int Q       = 3329,
  parameter int N_PAIRS = 128,
  parameter int AW      = 7
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_rd_en,
  input  logic [23:0]   i_a_pair,
  input  logic [23:0]   i_b_pair,
  output logic [AW-2:0] o_zeta_idx,
  input  logic [11:0]   i_zeta,
  output logic          o_bm_en,
  output logic [11:0]   o_bm_p_h,
  output logic [11:0]   o_bm_p_l,
  output logic [11:0]   o_bm_q_h,
  output logic [11:0]   o_bm_q_l,
  output logic [11:0]   o_bm_zeta,
  input  logic [11:0]   i_bm_r_h,
  input  logic [11:0]   i_bm_r_l,
  input  logic          i_bm_done,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [23:0]   o_wr_data
`ifdef PBM_CYCLE_COUNT_EN
  ,
  output logic [15:0]   o_cycles
`endif
);

  localparam logic [11:0]   Q12    = 12'(Q);
  localparam logic [AW-1:0] LAST_K = AW'(N_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_RUN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] k_q, k_d;
  logic [11:0]   p_h_q, p_l_q, q_h_q, q_l_q, zeta_q;
  logic [23:0]   res_q;

  // Odd pairs use -zeta. Zero maps to zero so the output never equals Q.
  function automatic logic [11:0] neg_zeta(input logic [11:0] z);
    return (z == 12'd0) ? 12'd0 : Q12 - z;
  endfunction

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        k_d = '0;
        if (i_start) state_d = S_READ;
      end
      S_READ:  state_d = S_LATCH;
      S_LATCH: state_d = S_RUN;
      S_RUN: begin
        if (i_bm_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        k_d     = k_q + 1'b1;
        state_d = (k_q == LAST_K) ? S_DONE : S_READ;
      end
      S_DONE: begin
        k_d     = '0;
        state_d = S_IDLE;
      end
      default: begin
        k_d     = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand and result registers. Operands are captured once per pair in
  // LATCH (read data arrives one cycle after READ) and stay stable through
  // RUN and WRITE. The result is only taken while RUN sees a done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_h_q  <= '0;
      p_l_q  <= '0;
      q_h_q  <= '0;
      q_l_q  <= '0;
      zeta_q <= '0;
      res_q  <= '0;
    end else begin
      if (state_q == S_LATCH) begin
        p_h_q  <= i_a_pair[23:12];
        p_l_q  <= i_a_pair[11:0];
        q_h_q  <= i_b_pair[23:12];
        q_l_q  <= i_b_pair[11:0];
        zeta_q <= k_q[0] ? neg_zeta(i_zeta) : i_zeta;
      end
      if (state_q == S_RUN && i_bm_done) begin
        res_q <= {i_bm_r_h, i_bm_r_l};
      end
    end
  end

  // Output logic. Enable drops in WRITE so basemul is back in its idle
  // state with en low and cannot re-trigger on the same operands.
  always_comb begin
    o_busy     = (state_q != S_IDLE);
    o_done     = (state_q == S_DONE);
    o_rd_en    = (state_q == S_READ);
    o_rd_addr  = (state_q == S_READ) ? k_q : '0;
    o_zeta_idx = (state_q == S_READ) ? k_q[AW-1:1] : '0;
    o_bm_en    = (state_q == S_RUN);
    o_wr_en    = (state_q == S_WRITE);
    o_wr_addr  = (state_q == S_WRITE) ? k_q : '0;
    o_wr_data  = (state_q == S_WRITE) ? res_q : '0;
    o_bm_p_h   = p_h_q;
    o_bm_p_l   = p_l_q;
    o_bm_q_h   = q_h_q;
    o_bm_q_l   = q_l_q;
    o_bm_zeta  = zeta_q;
  end

`ifdef PBM_CYCLE_COUNT_EN
  // Cleared when a start is accepted, counts every busy cycle (DONE
  // included), then holds until the next accepted start.
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE && i_start) cyc_d = '0;
    else if (state_q != S_IDLE)       cyc_d = cyc_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) cyc_q <= '0;
    else       cyc_q <= cyc_d;
  end

  assign o_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_poly_basemul_ctrl.sv
module tb_poly_basemul_ctrl;

  localparam int    NP = 128;
  localparam longint QL = 3329;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, rd_en, bm_en, wr_en;
  logic [6:0]  rd_addr, wr_addr;
  logic [5:0]  zidx;
  logic [23:0] a_pair, b_pair, wr_data;
  logic [11:0] zeta, p_h, p_l, q_h, q_l, bm_zeta;
  logic        bm_done;
  logic [11:0] bm_rh, bm_rl;
`ifdef PBM_CYCLE_COUNT_EN
  logic [15:0] cycles;
`endif

  always #5 clk = ~clk;

  poly_basemul_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_busy(busy), .o_done(done),
    .o_rd_addr(rd_addr), .o_rd_en(rd_en),
    .i_a_pair(a_pair), .i_b_pair(b_pair),
    .o_zeta_idx(zidx), .i_zeta(zeta),
    .o_bm_en(bm_en),
    .o_bm_p_h(p_h), .o_bm_p_l(p_l), .o_bm_q_h(q_h), .o_bm_q_l(q_l),
    .o_bm_zeta(bm_zeta),
    .i_bm_r_h(bm_rh), .i_bm_r_l(bm_rl), .i_bm_done(bm_done),
    .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data)
`ifdef PBM_CYCLE_COUNT_EN
    , .o_cycles(cycles)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;

  logic [23:0] a_mem [NP];
  logic [23:0] b_mem [NP];
  logic [11:0] zrom  [64];
  logic [30:0] exp_q [$];

  logic [108:0] outs;
  assign outs = {busy, done, rd_addr, rd_en, zidx, bm_en, p_h, p_l, q_h, q_l,
                 bm_zeta, wr_en, wr_addr, wr_data};

  // Memory / zeta ROM with one-cycle read latency; garbage when not read.
  always @(posedge clk) begin
    if (rd_en) begin
      a_pair <= a_mem[rd_addr];
      b_pair <= b_mem[rd_addr];
      zeta   <= zrom[zidx];
    end else begin
      a_pair <= 24'hFFFFFF;
      b_pair <= 24'hFFFFFF;
      zeta   <= 12'hFFF;
    end
  end

  // Basemul environment: done after bm_lat cycles of en; optional spurious
  // done pulses with junk data whenever en is low.
  int bm_lat = 0;
  int bm_cnt = 0;
  bit bm_spur = 1'b0;

  always_comb begin
    bm_done = 1'b0;
    bm_rh   = '0;
    bm_rl   = '0;
    if (bm_en && bm_cnt == bm_lat) begin
      bm_done = 1'b1;
      bm_rh = 12'((longint'(p_l) * longint'(q_h) + longint'(p_h) * longint'(q_l)) % QL);
      bm_rl = 12'(((longint'(p_h) * longint'(q_h)) % QL * longint'(bm_zeta)
                   + longint'(p_l) * longint'(q_l)) % QL);
    end else if (!bm_en && bm_spur) begin
      bm_done = 1'b1;
      bm_rh   = 12'hABC;
      bm_rl   = 12'h123;
    end
  end

  always @(posedge clk) begin
    if (bm_en && !bm_done) bm_cnt <= bm_cnt + 1;
    else                   bm_cnt <= 0;
  end

  // Scoreboard: every write pops one expected {addr, data}.
  always @(negedge clk) begin
    logic [30:0] e;
    if (rd_en) rd_cnt++;
    if (bm_done && bm_en) begin
      n_vec++;
      if (longint'(bm_zeta) >= QL) begin
        n_err++;
        $display("FAIL bm_zeta_range: got %0d, required < 3329", bm_zeta);
      end
    end
    if (wr_en) begin
      wr_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got addr %0d data %h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_err++;
          $display("FAIL wr_word: got addr %0d data %h, required addr %0d data %h",
                   wr_addr, wr_data, e[30:24], e[23:0]);
        end
      end
      n_vec++;
      if (longint'(wr_data[23:12]) >= QL || longint'(wr_data[11:0]) >= QL) begin
        n_err++;
        $display("FAIL wr_range: got %h, required both coefs < 3329", wr_data);
      end
    end
  end

  // Software Kyber basemul for pair k.
  function automatic logic [23:0] ref_word(input int k);
    longint a1 = longint'(a_mem[k][23:12]);
    longint a0 = longint'(a_mem[k][11:0]);
    longint b1 = longint'(b_mem[k][23:12]);
    longint b0 = longint'(b_mem[k][11:0]);
    longint z  = longint'(zrom[k / 2]);
    longint r0, r1;
    if (k % 2 == 1) z = (QL - z) % QL;
    r0 = ((a1 * b1) % QL * z + a0 * b0) % QL;
    r1 = (a0 * b1 + a1 * b0) % QL;
    return {12'(r1), 12'(r0)};
  endfunction

  // Start a pass and wait for o_done. act: 0 none, 1 pulse start after 40
  // writes, 2 reset after 40 writes (returns right after reset).
  task automatic run_pass(input int act, output int cyc, output bit ok);
    int  base;
    bit  fired;
    base  = wr_cnt;
    fired = 1'b0;
    ok    = 1'b0;
    cyc   = 0;
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    while (cyc < 3000) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (act != 0 && !fired && wr_cnt == base + 40) begin
        fired = 1'b1;
        if (act == 1) begin
          start = 1'b1;
        end else begin
          rst = 1'b1;
          exp_q.delete();
          @(negedge clk);
          #1;
          rst = 1'b0;
          return;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (outs !== '0) begin
        n_err++;
        $display("FAIL idle_outputs cycle %0d: got %h, required 0", i, outs);
      end
    end
  endtask

  task automatic test_zeta_neg();
    int cyc, base;
    bit ok;
    for (int k = 0; k < NP; k++) begin
      a_mem[k] = 24'h001000;
      b_mem[k] = 24'h001000;
      exp_q.push_back({7'(k), (k % 2 == 0) ? 24'd17 : 24'd3312});
    end
    for (int i = 0; i < 64; i++) zrom[i] = 12'd17;
    base = wr_cnt;
    run_pass(0, cyc, ok);
    n_vec++;
    if (!ok || cyc != 512) begin
      n_err++;
      $display("FAIL done_latency: got %0d cycles (ok=%0d), required 512", cyc, ok);
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_at_done: got %b, required 1", busy);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL busy_after_done: got busy %b done %b, required 0 0", busy, done);
    end
`ifdef PBM_CYCLE_COUNT_EN
    repeat (3) @(negedge clk);
    n_vec++;
    if (cycles !== 16'd513) begin
      n_err++;
      $display("FAIL cycle_count: got %0d, required 513", cycles);
    end
`endif
    n_vec++;
    if (wr_cnt - base != NP || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL zeta_write_count: got %0d (left %0d), required 128", wr_cnt - base, exp_q.size());
    end
  endtask

  task automatic test_addr_order();
    int cyc, base;
    bit ok;
    for (int k = 0; k < NP; k++) begin
      a_mem[k] = 24'h000001;
      b_mem[k] = 24'h000005;
      exp_q.push_back({7'(k), 24'h000005});
    end
    base = wr_cnt;
    run_pass(0, cyc, ok);
    @(negedge clk);
    n_vec++;
    if (!ok || wr_cnt - base != NP || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL addr_order_count: got %0d writes (ok=%0d), required 128", wr_cnt - base, ok);
    end
  endtask

  task automatic test_start_during_busy();
    int cyc, base;
    bit ok;
    for (int k = 0; k < NP; k++) begin
      a_mem[k] = {12'(k), 12'(3 * k + 1)};
      b_mem[k] = {12'(2 * k + 7), 12'(k + 100)};
      exp_q.push_back({7'(k), ref_word(k)});
    end
    base = wr_cnt;
    run_pass(1, cyc, ok);
    n_vec++;
    if (!ok || cyc != 512) begin
      n_err++;
      $display("FAIL start_busy_latency: got %0d (ok=%0d), required 512", cyc, ok);
    end
    start = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || rd_en !== 1'b0) begin
      n_err++;
      $display("FAIL start_at_done: got busy %b rd_en %b, required 0 0", busy, rd_en);
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || wr_cnt - base != NP || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL start_busy_writes: got busy %b writes %0d, required 0 128", busy, wr_cnt - base);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc, base, rbase;
    bit ok;
    for (int k = 0; k < NP; k++) exp_q.push_back({7'(k), ref_word(k)});
    base = wr_cnt;
    run_pass(2, cyc, ok);
    n_vec++;
    if (outs !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got %h, required 0", outs);
    end
    rbase = rd_cnt;
    repeat (20) @(negedge clk);
    n_vec++;
    if (wr_cnt - base != 40 || rd_cnt != rbase) begin
      n_err++;
      $display("FAIL mid_reset_quiet: got writes %0d reads %0d, required 40 0", wr_cnt - base, rd_cnt - rbase);
    end
    for (int k = 0; k < NP; k++) exp_q.push_back({7'(k), ref_word(k)});
    base = wr_cnt;
    run_pass(0, cyc, ok);
    @(negedge clk);
    n_vec++;
    if (!ok || wr_cnt - base != NP || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL restart_after_reset: got %0d writes (ok=%0d), required 128", wr_cnt - base, ok);
    end
  endtask

  task automatic test_random();
    int cyc, base;
    bit ok;
    for (int k = 0; k < NP; k++) begin
      a_mem[k] = {12'($urandom_range(3328)), 12'($urandom_range(3328))};
      b_mem[k] = {12'($urandom_range(3328)), 12'($urandom_range(3328))};
    end
    for (int i = 0; i < 64; i++) zrom[i] = 12'($urandom_range(3328));
    zrom[0] = 12'd1;
    zrom[5] = 12'd0;
    zrom[6] = 12'd3328;
    for (int k = 0; k < NP; k++) exp_q.push_back({7'(k), ref_word(k)});
    bm_lat  = 2;
    bm_spur = 1'b1;
    base = wr_cnt;
    run_pass(0, cyc, ok);
    @(negedge clk);
    bm_spur = 1'b0;
    bm_lat  = 0;
    n_vec++;
    if (!ok || cyc != NP * 6 || wr_cnt - base != NP || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL random_run: got %0d cycles %0d writes (ok=%0d), required 768 128",
               cyc, wr_cnt - base, ok);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    test_reset();
    test_zeta_neg();
    test_addr_order();
    test_start_during_busy();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
